// File: rtl/alu_serial_datapath_pkg.sv
// Shared types and constants for the digit-serial ALU datapath.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_PAR  = 2'b10,
        ALU_COMP = 2'b11
    } alu_op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

endpackage

// File: rtl/alu_serial_datapath_slice.sv
// One digit of ADD/SUB/PAR/COMP: combinational step from the current
// accumulators to their next values plus the produced result digit.
module alu_digit_slice
    import alu_pkg::*;
#(
    parameter int DIGIT_WIDTH = 2
) (
    input  logic [DIGIT_WIDTH-1:0] da,
    input  logic [DIGIT_WIDTH-1:0] db,
    input  alu_op_t                opcode,
    input  logic                   cin,
    input  logic                   eq,
    input  logic                   gt,
    input  logic                   parity,
    output logic [DIGIT_WIDTH-1:0] digit,
    output logic                   cout,
    output logic                   eq_next,
    output logic                   gt_next,
    output logic                   parity_next
);

    logic [DIGIT_WIDTH:0] sum;
    logic [DIGIT_WIDTH:0] diff;

    // The extra top bit of each extended result is the carry / borrow out.
    assign sum  = {1'b0, da} + {1'b0, db} + {{DIGIT_WIDTH{1'b0}}, cin};
    assign diff = {1'b0, da} - {1'b0, db} - {{DIGIT_WIDTH{1'b0}}, cin};

    // Select the digit result and update only the accumulator the opcode owns.
    always_comb begin
        digit       = '0;
        cout        = OFF;
        eq_next     = eq;
        gt_next     = gt;
        parity_next = parity;
        case (opcode)
            ALU_ADD: begin
                digit = sum[DIGIT_WIDTH-1:0];
                cout  = sum[DIGIT_WIDTH];
            end
            ALU_SUB: begin
                digit = diff[DIGIT_WIDTH-1:0];
                cout  = diff[DIGIT_WIDTH];
            end
            ALU_PAR: parity_next = parity ^ (^(da ^ db));
            ALU_COMP: begin
                // Digits arrive LSB first, so a higher digit overrides gt.
                gt_next = (da > db) | ((da == db) & gt);
                eq_next = eq & (da == db);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_serial_datapath.sv
// Digit-serial ALU: two operand buffers, private shift copies for the
// operation in flight, one digit per clock LSB first, one-cycle done pulse.
module alu_serial_datapath
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DIGIT_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic [1:0]            opcode_value,
    input  logic                  store_a,
    input  logic                  store_b,
    input  logic                  start,
    output logic                  busy,
    output logic                  alu_done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                  state, state_next;
    logic                    accept, step, finish, last;
    logic [DATA_WIDTH-1:0]   buf_a, buf_b, sh_a, sh_b, acc, acc_next;
    logic [CW-1:0]           cnt;
    alu_op_t                 op;
    logic                    carry, eq, gt, parity;
    logic [DIGIT_WIDTH-1:0]  digit;
    logic                    cout, eq_next, gt_next, parity_next;

    assign last = (cnt == CW'(NUM_DIGITS - 1));

    // New sum/difference digits enter from the MSB side of the accumulator.
    assign acc_next = DATA_WIDTH'({digit, acc} >> DIGIT_WIDTH);

    alu_digit_slice #(.DIGIT_WIDTH(DIGIT_WIDTH)) u_slice (
        .da          (sh_a[DIGIT_WIDTH-1:0]),
        .db          (sh_b[DIGIT_WIDTH-1:0]),
        .opcode      (op),
        .cin         (carry),
        .eq          (eq),
        .gt          (gt),
        .parity      (parity),
        .digit       (digit),
        .cout        (cout),
        .eq_next     (eq_next),
        .gt_next     (gt_next),
        .parity_next (parity_next)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state: start only counts in IDLE, RUN ends on the last digit.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes and the busy flag.
    always_comb begin
        accept = OFF;
        step   = OFF;
        finish = OFF;
        busy   = OFF;
        case (state)
            S_IDLE: accept = start;
            S_RUN: begin
                busy   = ON;
                step   = ON;
                finish = last;
            end
            default: ;
        endcase
    end

    // Operand buffers are loadable at any time; running work uses sh_a/sh_b.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_a <= '0;
            buf_b <= '0;
        end else begin
            if (store_a) buf_a <= alu_data;
            if (store_b) buf_b <= alu_data;
        end
    end

    // Operation core: snapshot on accept (old buffer values), then one digit per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a   <= '0;
            sh_b   <= '0;
            acc    <= '0;
            cnt    <= '0;
            op     <= ALU_ADD;
            carry  <= OFF;
            parity <= OFF;
            eq     <= OFF;
            gt     <= OFF;
        end else if (accept) begin
            sh_a   <= buf_a;
            sh_b   <= buf_b;
            acc    <= '0;
            cnt    <= '0;
            op     <= alu_op_t'(opcode_value);
            carry  <= OFF;
            parity <= OFF;
            eq     <= ON;
            gt     <= OFF;
        end else if (step) begin
            sh_a   <= sh_a >> DIGIT_WIDTH;
            sh_b   <= sh_b >> DIGIT_WIDTH;
            acc    <= acc_next;
            cnt    <= cnt + CW'(1);
            carry  <= cout;
            parity <= parity_next;
            eq     <= eq_next;
            gt     <= gt_next;
        end
    end

    // Result registers update only on the final digit; alu_done is a single pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_done <= OFF;
            result   <= '0;
            overflow <= OFF;
        end else begin
            alu_done <= finish;
            if (finish) begin
                case (op)
                    ALU_ADD, ALU_SUB: begin
                        result   <= acc_next;
                        overflow <= cout;
                    end
                    ALU_PAR: begin
                        result   <= DATA_WIDTH'(parity_next);
                        overflow <= OFF;
                    end
                    default: begin
                        result   <= DATA_WIDTH'({gt_next, eq_next});
                        overflow <= OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_datapath.sv
// Self-checking bench: four DUTs (DIGIT_WIDTH 1/2/4/8, DATA_WIDTH 8) share
// one stimulus; each has a transaction-level model compared every cycle.
// Instance 1 (DIGIT_WIDTH=2) also gets literal directed checks.
module tb_alu_serial_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] alu_data = 8'h00;
    logic [1:0] opcode = 2'b00;
    logic       store_a = 1'b0;
    logic       store_b = 1'b0;
    logic       start = 1'b0;

    logic [3:0] busy_v, done_v, ovf_v;
    logic [7:0] res_v [4];

    int   checks = 0;
    int   failures = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // {overflow, result} from plain arithmetic on whole operands.
    function automatic logic [8:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {8'h00, ^(a ^ b)};
            default: return {7'h00, (a > b), (a == b)};
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : sw
        localparam int DW = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;
        localparam int N  = 8 / DW;

        alu_serial_datapath #(.DATA_WIDTH(8), .DIGIT_WIDTH(DW)) dut (
            .clk          (clk),
            .reset        (reset),
            .alu_data     (alu_data),
            .opcode_value (opcode),
            .store_a      (store_a),
            .store_b      (store_b),
            .start        (start),
            .busy         (busy_v[g]),
            .alu_done     (done_v[g]),
            .result       (res_v[g]),
            .overflow     (ovf_v[g])
        );

        logic [7:0] ma, mb, m_res;
        logic [8:0] pend;
        logic       m_busy, m_done, m_ovf;
        int         rem;

        // Model: an accepted start finishes N edges later; stores land after start sampling.
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                ma = 0; mb = 0; m_res = 0; m_ovf = 0;
                m_busy = 0; m_done = 0; rem = 0; pend = 0;
            end else begin
                m_done = 0;
                if (!m_busy) begin
                    if (start) begin
                        m_busy = 1;
                        rem    = N;
                        pend   = ref_op(opcode, ma, mb);
                    end
                end else begin
                    rem--;
                    if (rem == 0) begin
                        m_busy = 0;
                        m_done = 1;
                        {m_ovf, m_res} = pend;
                    end
                end
                if (store_a) ma = alu_data;
                if (store_b) mb = alu_data;
            end
        end

        // Cycle compare, sampled on the falling edge.
        always @(negedge clk) begin
            if (chk_en) begin
                check($sformatf("dw%0d_busy", DW), 32'(busy_v[g]), 32'(m_busy));
                check($sformatf("dw%0d_done", DW), 32'(done_v[g]), 32'(m_done));
                check($sformatf("dw%0d_result", DW), 32'(res_v[g]), 32'(m_res));
                check($sformatf("dw%0d_overflow", DW), 32'(ovf_v[g]), 32'(m_ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        store_a = 1; alu_data = a; tick();
        store_a = 0; store_b = 1; alu_data = b; tick();
        store_b = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_v != 4'b0000 && n < 40) begin
            tick();
            n++;
        end
        check("idle_wait", 32'(busy_v), 32'h0);
    endtask

    // Waits (bounded) for instance 1's done pulse; n = negedges seen before it.
    task automatic wait_done(output int n, output logic got);
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (done_v[1]) got = 1;
            else n++;
        end
    endtask

    task automatic run(input string nm, input logic [1:0] op, input logic [7:0] er, input logic eo);
        int n;
        logic got;
        wait_idle();
        opcode = op; start = 1; tick(); start = 0;
        wait_done(n, got);
        check({nm, "_done"}, 32'(got), 32'h1);
        check({nm, "_latency"}, 32'(n), 32'd4);
        check({nm, "_result"}, 32'(res_v[1]), 32'(er));
        check({nm, "_overflow"}, 32'(ovf_v[1]), 32'(eo));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   n, cnt, last;
        logic got;

        #1 reset = 1;
        #1 chk_en = 1;
        tick(); tick();
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_done", 32'(done_v), 32'h0);
        check("rst_result", 32'(res_v[1]), 32'h0);
        check("rst_overflow", 32'(ovf_v), 32'h0);
        reset = 0;
        tick();

        load(8'hFF, 8'h01); run("add_wrap", 2'b00, 8'h00, 1'b1);
        load(8'h10, 8'h20); run("sub_borrow", 2'b01, 8'hF0, 1'b1);
        load(8'h20, 8'h10); run("sub_plain", 2'b01, 8'h10, 1'b0);
        load(8'h03, 8'h01); run("par", 2'b10, 8'h01, 1'b0);
        load(8'h80, 8'h7F); run("comp_gt", 2'b11, 8'h02, 1'b0);
        load(8'h5A, 8'h5A); run("comp_eq", 2'b11, 8'h01, 1'b0);
        load(8'h00, 8'h01); run("comp_lt", 2'b11, 8'h00, 1'b0);

        // start while busy at E2 is dropped
        wait_idle(); load(8'h01, 8'h02);
        opcode = 2'b00; start = 1; tick();
        start = 0; tick();
        start = 1; opcode = 2'b01; tick();
        start = 0;
        cnt = 0;
        repeat (12) begin @(negedge clk); if (done_v[1]) cnt++; end
        check("busy_start_dones", 32'(cnt), 32'd1);
        check("busy_start_result", 32'(res_v[1]), 32'h03);

        // store_a during RUN does not disturb the running add
        wait_idle(); load(8'h10, 8'h01);
        opcode = 2'b00; start = 1; tick();
        start = 0; store_a = 1; alu_data = 8'h33; tick();
        store_a = 0;
        wait_done(n, got);
        check("run_store_done", 32'(got), 32'h1);
        check("run_store_result", 32'(res_v[1]), 32'h11);
        run("add_new_a", 2'b00, 8'h34, 1'b0);

        // start and store_a together: operation sees the old A
        wait_idle(); load(8'h05, 8'h01);
        opcode = 2'b00; start = 1; store_a = 1; alu_data = 8'h40; tick();
        start = 0; store_a = 0;
        wait_done(n, got);
        check("same_cycle_done", 32'(got), 32'h1);
        check("same_cycle_result", 32'(res_v[1]), 32'h06);
        run("add_after_same", 2'b00, 8'h41, 1'b0);

        // reset in the middle of RUN
        wait_idle(); load(8'h12, 8'h34);
        opcode = 2'b00; start = 1; tick();
        start = 0; tick(); tick();
        reset = 1; #1;
        check("midrst_busy", 32'(busy_v), 32'h0);
        check("midrst_done", 32'(done_v), 32'h0);
        check("midrst_result", 32'(res_v[1]), 32'h0);
        tick(); reset = 0;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (done_v[1]) cnt++; end
        check("midrst_no_done", 32'(cnt), 32'd0);
        load(8'h12, 8'h34); run("after_rst", 2'b00, 8'h46, 1'b0);

        // start held high: one completion every N+1 = 5 cycles
        wait_idle(); load(8'h11, 8'h22);
        opcode = 2'b00; start = 1; tick();
        cnt = 0; last = -1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done_v[1]) begin
                cnt++;
                if (last >= 0) check("b2b_period", 32'(k - last), 32'd5);
                last = k;
                check("b2b_result", 32'(res_v[1]), 32'h33);
            end
        end
        start = 0;
        check("b2b_count", 32'(cnt), 32'd5);

        // random traffic across all digit widths, model-checked every cycle
        wait_idle();
        repeat (400) begin
            alu_data = 8'($urandom);
            opcode   = 2'($urandom);
            start    = ($urandom_range(0, 2) == 0);
            store_a  = ($urandom_range(0, 3) == 0);
            store_b  = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 96) == 0);
            tick();
        end
        start = 0; store_a = 0; store_b = 0; reset = 0;
        tick();
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_serial_datapath.md
# alu_serial_datapath

Parametrised, digit-serial successor to the single-shot ALU datapath. Holds two operand buffers loaded from a shared data bus and runs ADD, SUB, PAR or COMP on them DIGIT_WIDTH bits per clock, LSB digit first. Signals completion with a one-cycle `alu_done` pulse and holds the result until the next operation completes. It sits between the lab bus controller, which drives `alu_data`, `store_a`, `store_b`, `opcode_value` and `start`, and the result sink.

## Interface
- DATA_WIDTH, 8: operand and result width. Must be a multiple of DIGIT_WIDTH.
- DIGIT_WIDTH, 2: bits processed per cycle. NUM_DIGITS = DATA_WIDTH/DIGIT_WIDTH, and NUM_DIGITS must be at least 1.
- clk  in  1: single clock, rising edge.
- reset  in  1: reset, asynchronous, active-high.
- alu_data  in  DATA_WIDTH: operand bus.
- opcode_value  in  2: 00 ADD, 01 SUB, 10 PAR, 11 COMP. Sampled only with an accepted start.
- store_a  in  1: load `alu_data` into buffer A.
- store_b  in  1: load `alu_data` into buffer B.
- start  in  1: request an operation on the current buffers.
- busy  out  1: high while an operation is in flight.
- alu_done  out  1: one-cycle completion pulse.
- result  out  DATA_WIDTH: operation result, held between completions.
- overflow  out  1: carry-out for ADD, borrow-out for SUB, 0 for PAR and COMP.

## Operation
- States: IDLE and RUN.
- **Operand loading.** store_a and store_b are honoured in every state; asserting both loads both buffers. In-flight work uses private shift copies, so loading never disturbs a running operation.
- **Accepting start.** start is accepted only in IDLE.
  - It copies buffers A and B into the shift registers, latches the opcode and clears the digit counter.
  - It initialises the accumulators: carry/borrow 0, parity 0, eq 1, gt 0.
  - The FSM then moves to RUN.
  - If start and store_x are high in the same cycle, the operation uses the OLD buffer value and the buffer takes the new one.
- **RUN.** Each cycle processes one digit: da/db are the low DIGIT_WIDTH bits of the shift registers.
  - ADD: sum digit = da+db+carry, with carry out. Sum digits shift in from the MSB side.
  - SUB: diff digit = da-db-borrow, with borrow out.
  - PAR: parity ^= ^(da^db).
  - COMP: gt = (da>db) | ((da==db) & gt); eq = eq & (da==db). The comparison is unsigned.
- **Completion.** On the last digit (counter = NUM_DIGITS-1), the FSM registers result, overflow and alu_done=1 and returns to IDLE.
  - ADD/SUB: result is the full sum or difference modulo 2^DATA_WIDTH; overflow is the final carry or borrow.
  - PAR: result = {0…, parity}.
  - COMP: result = {0…, gt, eq}, i.e. bit1 = A>B and bit0 = A==B. Both bits 0 means A<B.
- start while busy is ignored; it is not queued.
- Outputs other than alu_done change only at completion.

## Timing
- Reset value of every output: busy=0, alu_done=0, result=0, overflow=0. Reset also clears the buffers, shift registers, counter and accumulators, and puts the FSM in IDLE.
- Reset mid-RUN aborts the operation with no alu_done pulse. After deassertion the block is in IDLE and accepts start on the next edge.
- Latency:
  - Start is sampled at edge E0, and busy=1 after E0.
  - Digits are processed at edges E1…EN, where N=NUM_DIGITS.
  - alu_done=1 and the new result are visible after EN; busy=0 after EN.
  - alu_done drops after EN+1.
- Throughput: a start held high or re-asserted at EN+1 is accepted there. The back-to-back period is N+1 cycles.
- NUM_DIGITS=1 is legal: RUN lasts one cycle.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode enum (ALU_ADD, ALU_SUB, ALU_PAR, ALU_COMP);
  - the state typedef (S_IDLE, S_RUN);
  - ON/OFF constants.
- One natural sub-module, `alu_digit_slice`: combinational, parametrised by DIGIT_WIDTH.
  - Inputs: da, db, opcode, carry/borrow, eq, gt, parity.
  - Outputs: digit result and next accumulator values.
- The top level owns the buffers, shift registers, digit counter, FSM and output registers.

## Test plan
All scenarios use DATA_WIDTH=8, DIGIT_WIDTH=2 (N=4).
- **ADD wrap.** A=0xFF, B=0x01, ADD start at E0 -> alu_done pulse after E4 only, result=0x00, overflow=1; busy high E0..E4.
- **SUB borrow.** A=0x10, B=0x20, SUB -> result=0xF0, overflow=1. Then A=0x20, B=0x10 -> result=0x10, overflow=0.
- **PAR and COMP.**
  - PAR with A=0x03, B=0x01 -> result=0x01, overflow=0.
  - COMP with A=0x80, B=0x7F -> result=0x02.
  - COMP with A=B=0x5A -> result=0x01.
  - COMP with A=0x00, B=0x01 -> result=0x00.
- **Collisions.**
  - Start while busy at E2 is ignored: exactly one alu_done.
  - store_a=0x33 during RUN leaves the current result unchanged; the next ADD uses 0x33.
  - start and store_a in the same cycle -> the operation uses the old A.
- **Reset mid-RUN.** Reset at E2 -> all outputs 0 immediately, no alu_done, and a new start after release completes normally.
- **Back-to-back.** start held high -> alu_done pulses every 5 cycles. The sweep over DIGIT_WIDTH 1/2/4/8 matches a reference model for random operands.
